// File: rtl/any1_memseq.sv
// any1_memseq -- element sequencer for vector-style memory operations.
//
// Walks an element index (step) from 0 to len-1. Each element takes a
// minimum of three cycles:
//   GEN   : step is presented to the external address generator.
//   CAPT  : the generator's effective address (ea) is valid and is captured
//           together with the element index and the last-element flag.
//   ISSUE : the captured request is held on req_* until req_ready accepts it.
//
// Ports
//   clk, rst         clock (rising edge) and asynchronous active-high reset
//   start, len       begin a sequence of len elements (0..64), taken in IDLE only
//   abort            flush the running sequence back to IDLE without done
//   step             element index driven to the address generator
//   ea               effective address, valid one cycle after step
//   req_valid/adr/elem/last, req_ready
//                    memory request handshake toward the load/store unit
//   busy             high whenever a sequence is in progress
//   done             single-cycle pulse after the final element (or len=0 start)

module any1_memseq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  len,
    input  logic        abort,
    output logic [5:0]  step,
    input  logic [31:0] ea,
    output logic        req_valid,
    output logic [31:0] req_adr,
    output logic [5:0]  req_elem,
    output logic        req_last,
    input  logic        req_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        CAPT  = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  len_q, len_d;
    logic [5:0]  step_q, step_d;
    logic        req_valid_q, req_valid_d;
    logic [31:0] req_adr_q, req_adr_d;
    logic [5:0]  req_elem_q, req_elem_d;
    logic        req_last_q, req_last_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        step_d      = step_q;
        req_valid_d = req_valid_q;
        req_adr_d   = req_adr_q;
        req_elem_d  = req_elem_q;
        req_last_d  = req_last_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // abort alongside start in IDLE suppresses the start entirely
                if (start && !abort) begin
                    len_d = len;
                    if (len != 7'd0) begin
                        step_d  = 6'd0;
                        state_d = GEN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            GEN: begin
                state_d = CAPT;
            end
            CAPT: begin
                // len_q >= 1 here, so len_q - 1 never underflows
                req_adr_d   = ea;
                req_elem_d  = step_q;
                req_last_d  = ({1'b0, step_q} == (len_q - 7'd1));
                req_valid_d = 1'b1;
                state_d     = ISSUE;
            end
            ISSUE: begin
                if (req_ready) begin
                    req_valid_d = 1'b0;
                    if (req_last_q) begin
                        step_d  = 6'd0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        step_d  = step_q + 6'd1;
                        state_d = GEN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // abort wins over everything, including a same-cycle handshake
        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            step_d      = 6'd0;
            req_valid_d = 1'b0;
            done_d      = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= 7'd0;
            step_q      <= 6'd0;
            req_valid_q <= 1'b0;
            req_adr_q   <= 32'd0;
            req_elem_q  <= 6'd0;
            req_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            step_q      <= step_d;
            req_valid_q <= req_valid_d;
            req_adr_q   <= req_adr_d;
            req_elem_q  <= req_elem_d;
            req_last_q  <= req_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign step      = step_q;
    assign req_valid = req_valid_q;
    assign req_adr   = req_adr_q;
    assign req_elem  = req_elem_q;
    assign req_last  = req_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/any1_memseq.md
ANY1_MEMSEQ -- requirements
Module: any1_memseq

Interface
REQ-001 SHALL have ports: rst input 1 (asynchronous, active-high reset); clk input 1 (single clock, all state on rising edge).
REQ-002 SHALL have input start 1: request a new element sequence; sampled only in IDLE.
REQ-003 SHALL have input len 7: element count, 0..64, sampled with start.
REQ-004 SHALL have input abort 1: flush current sequence.
REQ-005 SHALL have output step 6: element index driven to the address generator.
REQ-006 SHALL have input ea 32: effective address from the address generator, valid one cycle after step is presented.
REQ-007 SHALL have outputs req_valid 1, req_adr 32, req_elem 6, req_last 1: memory request toward the load/store unit.
REQ-008 SHALL have input req_ready 1: request accepted when req_valid and req_ready are both high on a rising edge.
REQ-009 SHALL have outputs busy 1 (state not IDLE) and done 1 (one-cycle completion pulse).

Function
REQ-010 SHALL implement states IDLE, GEN, CAPT, ISSUE.
REQ-011 IDLE: start and len>0 SHALL latch len, set step=0, go to GEN.
REQ-012 IDLE: start and len=0 SHALL assert done for exactly the next cycle, stay IDLE, issue no request.
REQ-013 GEN: step held stable for one cycle (generator captures ea at the end of GEN); next state CAPT.
REQ-014 CAPT: req_adr SHALL register ea at the end of the cycle; req_elem SHALL register step; req_last SHALL register (step == len-1); next state ISSUE.
REQ-015 ISSUE: req_valid=1; req_adr, req_elem, req_last SHALL be constant while req_valid is high and req_ready is low.
REQ-016 ISSUE with handshake and not last: step SHALL increment by 1 and the state SHALL go to GEN.
REQ-017 ISSUE with handshake and last: state SHALL go to IDLE, done SHALL be high for the following cycle only, step SHALL return to 0.
REQ-018 Latency: start at edge N -> req_valid high in the cycle after edge N+2; minimum 3 cycles per element.
REQ-019 step SHALL never exceed len-1; len=64 SHALL issue elements 0..63, with no wrap-around before completion.
REQ-020 start SHALL be ignored in any state other than IDLE; len SHALL be sampled only on an accepted start.
REQ-021 abort in any non-IDLE state SHALL force IDLE at the next edge, drop req_valid, zero step, and not assert done.
REQ-022 abort SHALL take priority over a same-cycle handshake; a handshake in that cycle still counts as accepted by the consumer, but done SHALL NOT be asserted.
REQ-023 abort in IDLE SHALL have no effect; abort and start in the same IDLE cycle SHALL leave the block in IDLE.
REQ-024 busy SHALL be high in GEN, CAPT and ISSUE and low in IDLE, including during the done pulse.
REQ-025 req_valid SHALL be high only in ISSUE.

Reset
REQ-026 rst high SHALL immediately, without waiting for clk, set state=IDLE, step=0, req_valid=0, req_adr=0, req_elem=0, req_last=0, busy=0, done=0, latched len=0.
REQ-027 rst asserted mid-sequence SHALL abandon the sequence with no done pulse; the first start after rst deasserts SHALL behave as from power-up.

Verification
REQ-028 Bench SHALL model ea = 0x1000 + 8*step, registered one cycle. Scenario: len=4, req_ready=1 -> req_adr 0x1000, 0x1008, 0x1010, 0x1018, req_elem 0..3, req_last on element 3 only, one element every 3 cycles, done one cycle after the 4th handshake.
REQ-029 Scenario: len=2, req_ready low for 3 cycles on element 0 -> req_valid held, req_adr=0x1000 stable, then element 1 = 0x1008, done once.
REQ-030 Scenario: len=0 start -> done next cycle, req_valid never high, busy stays 0.
REQ-031 Scenario: len=8, abort during ISSUE of element 2 with req_ready=1 -> IDLE next cycle, step=0, no done, no element 3 request.
REQ-032 Scenario: start pulse while busy with len=5 during a len=3 run -> exactly 3 requests, then idle.
REQ-033 Scenario: rst pulse asynchronous mid-CAPT -> outputs zero before the next clk edge; a subsequent len=1 start -> single request 0x1000 with req_last=1.
